// File: rtl/clock_gate_ctrl.sv
// Idle-detect controller that produces the enable for a latch-based clock gater.
// Defining CLOCK_GATE_CTRL_STATS_EN adds a saturating gated-cycle counter.
module clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
`ifdef CLOCK_GATE_CTRL_STATS_EN
    parameter int STATS_W     = 32,
`endif
    parameter int CNT_W       = $clog2((IDLE_CYCLES > WAKE_CYCLES ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i__busy,
    input  logic               i__req_valid,
    input  logic               i__wake,
    output logic               o__req_ready,
    output logic               o__enable,
    output logic               o__gated
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0] o__gated_cycles
`endif
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        GATED  = 2'd2,
        WAKE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             idle;
    logic             enable_nxt;
    logic             ready_nxt;
    logic             gated_nxt;

    assign idle = !i__busy && !i__req_valid && !i__wake;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ACTIVE;
            cnt          <= '0;
            o__enable    <= 1'b1;
            o__req_ready <= 1'b1;
            o__gated     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o__enable    <= enable_nxt;
            o__req_ready <= ready_nxt;
            o__gated     <= gated_nxt;
        end
    end

    // NOTE: defaults at the top of every combinational block keep all paths assigned, so no latches.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ACTIVE: begin
                if (idle) begin
                    if (IDLE_CYCLES == 1) begin
                        state_nxt = GATED;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Any activity on the final count wins over gating.
                if (!idle) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_nxt = GATED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GATED: begin
                if (!idle) begin
                    state_nxt = WAKE;
                    cnt_nxt   = '0;
                end
            end
            WAKE: begin
                if (cnt == WAKE_LAST) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: outputs decode the next state and are then flopped, so the gater enable is glitch-free.
    always_comb begin
        enable_nxt = (state_nxt != GATED);
        ready_nxt  = (state_nxt == ACTIVE) || (state_nxt == DRAIN);
        gated_nxt  = (state_nxt == GATED);
    end

`ifdef CLOCK_GATE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o__gated_cycles <= '0;
        end else if (!o__enable && (o__gated_cycles != {STATS_W{1'b1}})) begin
            o__gated_cycles <= o__gated_cycles + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2): directed table,
// multi-cycle corner sequences and randomized traffic against a behavioural model.
module tb_clock_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk;
    logic reset;
    logic busy;
    logic req_valid;
    logic wake;
    logic req_ready;
    logic enable;
    logic gated;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [SW-1:0] gated_cycles;
`endif

    int tests;
    int failed;

`ifdef CLOCK_GATE_CTRL_STATS_EN
    clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .STATS_W(SW)) dut (
        .clk(clk), .reset(reset), .i__busy(busy), .i__req_valid(req_valid), .i__wake(wake),
        .o__req_ready(req_ready), .o__enable(enable), .o__gated(gated),
        .o__gated_cycles(gated_cycles)
    );
`else
    clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
        .clk(clk), .reset(reset), .i__busy(busy), .i__req_valid(req_valid), .i__wake(wake),
        .o__req_ready(req_ready), .o__enable(enable), .o__gated(gated)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic b;
        logic v;
        logic w;
        logic en;
        logic rdy;
        logic gt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: gated flag, remaining warm-up edges, length of current idle run.
    bit m_gated;
    int m_wake_left;
    int m_idle_run;
    int m_stat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic b, input logic v, input logic w,
                       input logic en, input logic rdy, input logic gt);
        vec_t t;
        t.b = b; t.v = v; t.w = w; t.en = en; t.rdy = rdy; t.gt = gt;
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_gated     = 1'b0;
        m_wake_left = 0;
        m_idle_run  = 0;
        m_stat      = 0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic w);
        bit is_idle;
        is_idle = !b && !v && !w;
        if (m_gated && m_stat < SMAX) m_stat++;
        if (m_gated) begin
            if (!is_idle) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE;
                m_idle_run  = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else begin
            m_idle_run = is_idle ? m_idle_run + 1 : 0;
            if (m_idle_run == IDLE) begin
                m_gated    = 1'b1;
                m_idle_run = 0;
            end
        end
    endtask

    function automatic bit model_ready();
        return !m_gated && (m_wake_left == 0);
    endfunction

    task automatic do_reset();
        busy = 1'b0; req_valid = 1'b0; wake = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tests = 0;
        failed = 0;
        busy = 1'b0; req_valid = 1'b0; wake = 1'b0;
        reset = 1'b1;
        #3;
        check("reset_enable", 32'(enable), 32'd1);
        check("reset_ready",  32'(req_ready), 32'd1);
        check("reset_gated",  32'(gated), 32'd0);
`ifdef CLOCK_GATE_CTRL_STATS_EN
        check("reset_stats",  32'(gated_cycles), 32'd0);
`endif
        step();
        reset = 1'b0;

        // Directed table: each row is inputs for one edge and outputs expected after it.
        // Four idle edges gate the clock.
        add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 0,0,1);
        // Request wakes: enable after T, ready after T+2, accepted at T+3.
        add(0,1,0, 1,0,0); add(0,1,0, 1,0,0); add(0,1,0, 1,1,0); add(0,1,0, 1,1,0);
        // Three idle then busy: no gating; then a fresh run of four gates.
        add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(1,0,0, 1,1,0);
        add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 0,0,1);
        // Wake pulse: two warm-up cycles despite idle inputs, then gates again after four idles.
        add(0,0,1, 1,0,0); add(0,0,0, 1,0,0); add(0,0,0, 1,1,0);
        add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 0,0,1);
        // Busy while gated acts as a wake.
        add(1,0,0, 1,0,0); add(1,0,0, 1,0,0); add(1,0,0, 1,1,0); add(1,0,0, 1,1,0);
        // Request on the final drain count returns to ACTIVE instead of gating.
        add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,0,0, 1,1,0); add(0,1,0, 1,1,0);
        add(0,0,0, 1,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            busy = vecs[i].b; req_valid = vecs[i].v; wake = vecs[i].w;
            step();
            check($sformatf("vec%0d_enable", i), 32'(enable),    32'(vecs[i].en));
            check($sformatf("vec%0d_ready", i),  32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_gated", i),  32'(gated),     32'(vecs[i].gt));
        end

        // Asynchronous reset in the middle of a wake.
        do_reset();
        for (int i = 0; i < IDLE + 3; i++) step();
        check("pre_wake_gated", 32'(gated), 32'd1);
        wake = 1'b1;
        step();
        wake = 1'b0;
        check("mid_wake_ready", 32'(req_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_enable", 32'(enable), 32'd1);
        check("async_rst_ready",  32'(req_ready), 32'd1);
        check("async_rst_gated",  32'(gated), 32'd0);
`ifdef CLOCK_GATE_CTRL_STATS_EN
        check("async_rst_stats",  32'(gated_cycles), 32'd0);
`endif
        step();
        reset = 1'b0;
        model_reset();

`ifdef CLOCK_GATE_CTRL_STATS_EN
        // Long gated stretch: counter climbs then saturates at all-ones.
        for (int i = 0; i < IDLE; i++) step();
        for (int i = 0; i < 10; i++) step();
        check("stats_count10", 32'(gated_cycles), 32'd10);
        for (int i = 0; i < 10; i++) step();
        check("stats_saturate", 32'(gated_cycles), 32'(SMAX));
        do_reset();
`endif

        // Randomized traffic against the model; valid is held until accepted.
        begin
            logic hold_v;
            bit   accepted;
            hold_v = 1'b0;
            for (int i = 0; i < 800; i++) begin
                busy = ($urandom_range(0, 9) == 0);
                wake = ($urandom_range(0, 19) == 0);
                if (!hold_v) hold_v = ($urandom_range(0, 11) == 0);
                req_valid = hold_v;
                accepted = hold_v && model_ready();
                model_step(busy, req_valid, wake);
                step();
                check($sformatf("rnd%0d_enable", i), 32'(enable),    32'(!m_gated));
                check($sformatf("rnd%0d_ready", i),  32'(req_ready), 32'(model_ready()));
                check($sformatf("rnd%0d_gated", i),  32'(gated),     32'(m_gated));
`ifdef CLOCK_GATE_CTRL_STATS_EN
                check($sformatf("rnd%0d_stats", i),  32'(gated_cycles), 32'(m_stat));
`endif
                if (accepted) hold_v = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
